// File: rtl/user_demux_rd_q.sv
// user_demux_rd_q
// Queued read-path demultiplexer. Commands {len, dest} are buffered in a
// CMD_DEPTH-deep FIFO and executed one at a time. Each command steers
// ceil(len/BB) beats of the single source stream to output stream 'dest'.
// tlast is regenerated from the byte length. Commands with len==0 or
// dest>=N_ID pulse err; the latter also drain their beats so the source
// never stalls. Back-to-back commands run with no idle cycle between them.
//
// Ports:
//   aclk, aresetn        clock, asynchronous active-low reset
//   mux_valid/ready/data command input: dest in [DEST_BITS-1:0],
//                        byte length in [DEST_BITS +: LEN_BITS]
//   s_axis_*             source stream (s_axis_tlast is ignored)
//   m_axis_*             N_ID output streams, flattened, stream i in slice i
//   err                  one-cycle pulse when a bad command is popped
//   busy                 transfer active or commands queued
//   stat_beats           N_ID x 32 per-destination beat counters
//                        (only when USER_DEMUX_STATS_EN is defined)
//
// Optional feature macro: USER_DEMUX_STATS_EN
module user_demux_rd_q #(
  parameter int DATA_BITS = 512,
  parameter int N_ID      = 4,
  parameter int LEN_BITS  = 28,
  parameter int DEST_BITS = (N_ID > 1) ? $clog2(N_ID) : 1,
  parameter int PID_BITS  = 6,
  parameter int CMD_DEPTH = 4
) (
  input  logic                            aclk,
  input  logic                            aresetn,
  input  logic                            mux_valid,
  output logic                            mux_ready,
  input  logic [LEN_BITS+DEST_BITS-1:0]   mux_data,
  input  logic                            s_axis_tvalid,
  output logic                            s_axis_tready,
  input  logic [DATA_BITS-1:0]            s_axis_tdata,
  input  logic [DATA_BITS/8-1:0]          s_axis_tkeep,
  input  logic [PID_BITS-1:0]             s_axis_tid,
  input  logic                            s_axis_tlast,
  output logic [N_ID-1:0]                 m_axis_tvalid,
  input  logic [N_ID-1:0]                 m_axis_tready,
  output logic [N_ID*DATA_BITS-1:0]       m_axis_tdata,
  output logic [N_ID*(DATA_BITS/8)-1:0]   m_axis_tkeep,
  output logic [N_ID*PID_BITS-1:0]        m_axis_tid,
  output logic [N_ID-1:0]                 m_axis_tlast,
  output logic                            err,
  output logic                            busy
`ifdef USER_DEMUX_STATS_EN
  ,
  output logic [N_ID*32-1:0]              stat_beats
`endif
);

  localparam int BB        = DATA_BITS / 8;
  localparam int BB_LOG    = $clog2(BB);
  localparam int BLEN_BITS = LEN_BITS - BB_LOG;
  localparam int PTR_BITS  = $clog2(CMD_DEPTH);
  localparam int CMD_BITS  = LEN_BITS + DEST_BITS;

  typedef enum logic [1:0] {ST_IDLE, ST_MUX, ST_DRAIN} state_t;

  state_t                 state;
  logic [BLEN_BITS-1:0]   cnt;
  logic [DEST_BITS-1:0]   dest_q;
  logic                   rdy_en;

  logic [CMD_BITS-1:0]    cmd_mem [CMD_DEPTH];
  logic [PTR_BITS-1:0]    wr_ptr;
  logic [PTR_BITS-1:0]    rd_ptr;
  logic [PTR_BITS:0]      fill;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   push;
  logic                   pop;

  logic [CMD_BITS-1:0]    head;
  logic [DEST_BITS-1:0]   head_dest;
  logic [LEN_BITS-1:0]    head_len;
  logic [BLEN_BITS-1:0]   head_cnt;
  logic                   head_len_zero;
  logic                   head_dest_bad;

  logic                   cnt_last;
  logic                   beat_hs;
  logic                   sel_ready;

  logic                   unused_tlast;
  assign unused_tlast = s_axis_tlast;

  assign fifo_full  = (fill == (PTR_BITS+1)'(CMD_DEPTH));
  assign fifo_empty = (fill == '0);

  // rdy_en keeps mux_ready low until the first clock after reset release.
  assign mux_ready = rdy_en & ~fifo_full;
  assign push      = mux_valid & mux_ready;

  assign head          = cmd_mem[rd_ptr];
  assign head_dest     = head[DEST_BITS-1:0];
  assign head_len      = head[DEST_BITS +: LEN_BITS];
  assign head_len_zero = (head_len == '0);
  assign head_dest_bad = ({{(32-DEST_BITS){1'b0}}, head_dest} >= 32'(N_ID));

  // beats-1 = len[hi] + (len[lo]!=0) - 1; modular arithmetic keeps the
  // maximum length (which overflows the beat count by one) correct.
  assign head_cnt = head_len[LEN_BITS-1:BB_LOG]
                  + BLEN_BITS'(|head_len[BB_LOG-1:0])
                  - BLEN_BITS'(1);

  assign cnt_last = (cnt == '0);
  assign beat_hs  = s_axis_tvalid & s_axis_tready;

  // Pop when idle, or on the final beat so the next command starts with no bubble.
  assign pop = ~fifo_empty & ((state == ST_IDLE) | (beat_hs & cnt_last));

  assign busy = (state != ST_IDLE) | ~fifo_empty;

  assign m_axis_tdata = {N_ID{s_axis_tdata}};
  assign m_axis_tkeep = {N_ID{s_axis_tkeep}};
  assign m_axis_tid   = {N_ID{s_axis_tid}};

  always_comb begin
    m_axis_tvalid = '0;
    m_axis_tlast  = '0;
    sel_ready     = 1'b0;
    for (int i = 0; i < N_ID; i++) begin
      if (dest_q == DEST_BITS'(i)) begin
        sel_ready = m_axis_tready[i];
        if (state == ST_MUX) begin
          m_axis_tvalid[i] = s_axis_tvalid;
          m_axis_tlast[i]  = cnt_last;
        end
      end
    end
  end

  always_comb begin
    case (state)
      ST_MUX:   s_axis_tready = sel_ready;
      ST_DRAIN: s_axis_tready = 1'b1;
      default:  s_axis_tready = 1'b0;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (push) begin
      cmd_mem[wr_ptr] <= mux_data;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      dest_q <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
      err    <= 1'b0;
      rdy_en <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      err    <= 1'b0;

      if (push) begin
        wr_ptr <= wr_ptr + PTR_BITS'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_BITS'(1);
      end
      if (push && !pop) begin
        fill <= fill + (PTR_BITS+1)'(1);
      end else if (!push && pop) begin
        fill <= fill - (PTR_BITS+1)'(1);
      end

      if (pop) begin
        if (head_len_zero) begin
          err   <= 1'b1;
          state <= ST_IDLE;
        end else if (head_dest_bad) begin
          err   <= 1'b1;
          cnt   <= head_cnt;
          state <= ST_DRAIN;
        end else begin
          dest_q <= head_dest;
          cnt    <= head_cnt;
          state  <= ST_MUX;
        end
      end else if (beat_hs) begin
        if (cnt_last) begin
          state <= ST_IDLE;
        end else begin
          cnt <= cnt - BLEN_BITS'(1);
        end
      end
    end
  end

`ifdef USER_DEMUX_STATS_EN
  logic [31:0] stat_q [N_ID];

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < N_ID; i++) begin
        stat_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_ID; i++) begin
        if (beat_hs && (state == ST_MUX) && (dest_q == DEST_BITS'(i))) begin
          stat_q[i] <= stat_q[i] + 32'd1;
        end
      end
    end
  end

  always_comb begin
    stat_beats = '0;
    for (int i = 0; i < N_ID; i++) begin
      stat_beats[i*32 +: 32] = stat_q[i];
    end
  end
`endif

endmodule

// File: tb/tb_user_demux_rd_q.sv
// tb_user_demux_rd_q
// Self-checking bench for user_demux_rd_q (DATA_BITS=512, N_ID=4,
// CMD_DEPTH=4). DEST_BITS is widened to 3 so an out-of-range destination
// (dest=5) can be expressed. A cycle table covers single transfers,
// length rounding, bad commands and back-to-back commands; hand-written
// sequences cover backpressure, mid-transfer reset and a full command FIFO.
module tb_user_demux_rd_q;

  localparam int DATA_BITS = 512;
  localparam int N_ID      = 4;
  localparam int LEN_BITS  = 28;
  localparam int DEST_BITS = 3;
  localparam int PID_BITS  = 6;
  localparam int CMD_DEPTH = 4;
  localparam int BB        = DATA_BITS / 8;

  logic                          aclk;
  logic                          aresetn;
  logic                          mux_valid;
  logic                          mux_ready;
  logic [LEN_BITS+DEST_BITS-1:0] mux_data;
  logic                          s_axis_tvalid;
  logic                          s_axis_tready;
  logic [DATA_BITS-1:0]          s_axis_tdata;
  logic [BB-1:0]                 s_axis_tkeep;
  logic [PID_BITS-1:0]           s_axis_tid;
  logic                          s_axis_tlast;
  logic [N_ID-1:0]               m_axis_tvalid;
  logic [N_ID-1:0]               m_axis_tready;
  logic [N_ID*DATA_BITS-1:0]     m_axis_tdata;
  logic [N_ID*BB-1:0]            m_axis_tkeep;
  logic [N_ID*PID_BITS-1:0]      m_axis_tid;
  logic [N_ID-1:0]               m_axis_tlast;
  logic                          err;
  logic                          busy;
`ifdef USER_DEMUX_STATS_EN
  logic [N_ID*32-1:0]            stat_beats;
`endif

  user_demux_rd_q #(
    .DATA_BITS (DATA_BITS),
    .N_ID      (N_ID),
    .LEN_BITS  (LEN_BITS),
    .DEST_BITS (DEST_BITS),
    .PID_BITS  (PID_BITS),
    .CMD_DEPTH (CMD_DEPTH)
  ) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .mux_valid     (mux_valid),
    .mux_ready     (mux_ready),
    .mux_data      (mux_data),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tid    (s_axis_tid),
    .s_axis_tlast  (s_axis_tlast),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tid    (m_axis_tid),
    .m_axis_tlast  (m_axis_tlast),
    .err           (err),
    .busy          (busy)
`ifdef USER_DEMUX_STATS_EN
    ,
    .stat_beats    (stat_beats)
`endif
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int checks = 0;
  int errors = 0;

  // One record per clock cycle: inputs driven, then outputs expected in that cycle.
  typedef struct {
    logic                 mv;
    logic [DEST_BITS-1:0] dest;
    logic [LEN_BITS-1:0]  len;
    logic                 sv;
    logic                 sl;
    logic [N_ID-1:0]      mr;
    logic                 e_mux_ready;
    logic                 e_s_ready;
    logic [N_ID-1:0]      e_tvalid;
    logic [N_ID-1:0]      e_tlast;
    logic                 e_err;
    logic                 e_busy;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic mv, input int dest, input int len,
                              input logic sv, input logic sl, input logic [3:0] mr,
                              input logic e_mr, input logic e_sr,
                              input logic [3:0] e_tv, input logic [3:0] e_tl,
                              input logic e_err, input logic e_busy);
    vec_t v;
    v.mv          = mv;
    v.dest        = DEST_BITS'(dest);
    v.len         = LEN_BITS'(len);
    v.sv          = sv;
    v.sl          = sl;
    v.mr          = mr;
    v.e_mux_ready = e_mr;
    v.e_s_ready   = e_sr;
    v.e_tvalid    = e_tv;
    v.e_tlast     = e_tl;
    v.e_err       = e_err;
    v.e_busy      = e_busy;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int idx);
    vec_t v;
    v = vecs[idx];
    @(negedge aclk);
    mux_valid     = v.mv;
    mux_data      = {v.len, v.dest};
    s_axis_tvalid = v.sv;
    s_axis_tlast  = v.sl;
    m_axis_tready = v.mr;
    #1;
    checkOutput($sformatf("v%0d mux_ready", idx), 64'(mux_ready), 64'(v.e_mux_ready));
    checkOutput($sformatf("v%0d s_tready", idx), 64'(s_axis_tready), 64'(v.e_s_ready));
    checkOutput($sformatf("v%0d m_tvalid", idx), 64'(m_axis_tvalid), 64'(v.e_tvalid));
    checkOutput($sformatf("v%0d m_tlast", idx), 64'(m_axis_tlast), 64'(v.e_tlast));
    checkOutput($sformatf("v%0d err", idx), 64'(err), 64'(v.e_err));
    checkOutput($sformatf("v%0d busy", idx), 64'(busy), 64'(v.e_busy));
  endtask

  // 10-beat transfer to stream 1 with random backpressure; optionally
  // pulls reset after reset_at beats with a second command still queued.
  task automatic runTransfer(input int reset_at);
    int beats;
    int cycles;
    logic [31:0] word;
    beats  = 0;
    cycles = 0;
    @(negedge aclk);
    mux_valid     = 1'b1;
    mux_data      = {LEN_BITS'(640), DEST_BITS'(1)};
    s_axis_tvalid = 1'b0;
    m_axis_tready = 4'hF;
    @(negedge aclk);
    mux_valid = 1'b0;
    #1;
    checkOutput("t5 busy after cmd", 64'(busy), 64'd1);
    while (beats < 10 && cycles < 200) begin
      @(negedge aclk);
      cycles++;
      if (reset_at > 0 && beats == reset_at) begin
        aresetn       = 1'b0;
        s_axis_tvalid = 1'b1;
        m_axis_tready = 4'hF;
        #1;
        checkOutput("t5 rst s_tready", 64'(s_axis_tready), 64'd0);
        checkOutput("t5 rst m_tvalid", 64'(m_axis_tvalid), 64'd0);
        checkOutput("t5 rst m_tlast", 64'(m_axis_tlast), 64'd0);
        checkOutput("t5 rst mux_ready", 64'(mux_ready), 64'd0);
        checkOutput("t5 rst err", 64'(err), 64'd0);
        checkOutput("t5 rst busy", 64'(busy), 64'd0);
        @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
        #1;
        checkOutput("t5 post-rst busy", 64'(busy), 64'd0);
        checkOutput("t5 post-rst mux_ready", 64'(mux_ready), 64'd1);
        checkOutput("t5 post-rst s_tready", 64'(s_axis_tready), 64'd0);
        checkOutput("t5 post-rst m_tvalid", 64'(m_axis_tvalid), 64'd0);
        s_axis_tvalid = 1'b0;
        return;
      end
      mux_valid     = (reset_at > 0 && cycles == 1);
      mux_data      = {LEN_BITS'(64), DEST_BITS'(2)};
      m_axis_tready = 4'($urandom_range(0, 15));
      s_axis_tvalid = 1'b1;
      word          = 32'h1000 + 32'(beats);
      s_axis_tdata  = {480'd0, word};
      #1;
      checkOutput("t5 s_tready mirror", 64'(s_axis_tready), 64'(m_axis_tready[1]));
      checkOutput("t5 m_tvalid", 64'(m_axis_tvalid), 64'h2);
      if (s_axis_tready) begin
        checkOutput($sformatf("t5 beat%0d data", beats),
                    64'(m_axis_tdata[DATA_BITS +: 32]), 64'(word));
        checkOutput($sformatf("t5 beat%0d tlast", beats),
                    64'(m_axis_tlast[1]), 64'(beats == 9));
        beats++;
      end
    end
    mux_valid = 1'b0;
    checkOutput("t5 beat count", 64'(beats), 64'd10);
    checkOutput("t5 tid broadcast", 64'(m_axis_tid[PID_BITS +: PID_BITS]), 64'h2A);
    @(negedge aclk);
    m_axis_tready = 4'hF;
    #1;
    checkOutput("t5 idle m_tvalid", 64'(m_axis_tvalid), 64'd0);
    checkOutput("t5 idle busy", 64'(busy), 64'd0);
    s_axis_tvalid = 1'b0;
  endtask

  initial begin
    #200000;
    errors++;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    int exp_dest[5];
    int got;
    bit done;

    aresetn       = 1'b0;
    mux_valid     = 1'b0;
    mux_data      = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tkeep  = '1;
    s_axis_tid    = 6'h2A;
    s_axis_tlast  = 1'b0;
    m_axis_tready = 4'hF;

    // Test 1: dest=2, len=128
    vecs.push_back(mk(1, 2, 128, 0, 0, 4'hF, 1, 0, 4'b0000, 4'b0000, 0, 0));
    vecs.push_back(mk(0, 0,   0, 1, 0, 4'hF, 1, 0, 4'b0000, 4'b0000, 0, 1));
    vecs.push_back(mk(0, 0,   0, 1, 0, 4'hF, 1, 1, 4'b0100, 4'b0000, 0, 1));
    vecs.push_back(mk(0, 0,   0, 1, 0, 4'hF, 1, 1, 4'b0100, 4'b0100, 0, 1));
    vecs.push_back(mk(0, 0,   0, 1, 0, 4'hF, 1, 0, 4'b0000, 4'b0000, 0, 0));
    // Test 2: len=64, len=65 with misleading source tlast, len=0
    vecs.push_back(mk(1, 0,  64, 0, 0, 4'hF, 1, 0, 4'b0000, 4'b0000, 0, 0));
    vecs.push_back(mk(0, 0,   0, 1, 0, 4'hF, 1, 0, 4'b0000, 4'b0000, 0, 1));
    vecs.push_back(mk(0, 0,   0, 1, 0, 4'hF, 1, 1, 4'b0001, 4'b0001, 0, 1));
    vecs.push_back(mk(1, 3,  65, 0, 0, 4'hF, 1, 0, 4'b0000, 4'b0000, 0, 0));
    vecs.push_back(mk(0, 0,   0, 1, 1, 4'hF, 1, 0, 4'b0000, 4'b0000, 0, 1));
    vecs.push_back(mk(0, 0,   0, 1, 1, 4'hF, 1, 1, 4'b1000, 4'b0000, 0, 1));
    vecs.push_back(mk(0, 0,   0, 1, 0, 4'hF, 1, 1, 4'b1000, 4'b1000, 0, 1));
    vecs.push_back(mk(1, 1,   0, 0, 0, 4'hF, 1, 0, 4'b0000, 4'b0000, 0, 0));
    vecs.push_back(mk(0, 0,   0, 1, 0, 4'hF, 1, 0, 4'b0000, 4'b0000, 0, 1));
    vecs.push_back(mk(0, 0,   0, 1, 0, 4'hF, 1, 0, 4'b0000, 4'b0000, 1, 0));
    vecs.push_back(mk(0, 0,   0, 1, 0, 4'hF, 1, 0, 4'b0000, 4'b0000, 0, 0));
    // Test 3: back-to-back {dest0, 64} then {dest1, 192}
    vecs.push_back(mk(1, 0,  64, 0, 0, 4'hF, 1, 0, 4'b0000, 4'b0000, 0, 0));
    vecs.push_back(mk(1, 1, 192, 1, 0, 4'hF, 1, 0, 4'b0000, 4'b0000, 0, 1));
    vecs.push_back(mk(0, 0,   0, 1, 0, 4'hF, 1, 1, 4'b0001, 4'b0001, 0, 1));
    vecs.push_back(mk(0, 0,   0, 1, 0, 4'hF, 1, 1, 4'b0010, 4'b0000, 0, 1));
    vecs.push_back(mk(0, 0,   0, 1, 0, 4'hF, 1, 1, 4'b0010, 4'b0000, 0, 1));
    vecs.push_back(mk(0, 0,   0, 1, 0, 4'hF, 1, 1, 4'b0010, 4'b0010, 0, 1));
    vecs.push_back(mk(0, 0,   0, 1, 0, 4'hF, 1, 0, 4'b0000, 4'b0000, 0, 0));
    // Test 4: dest=5 drained, then dest=0 runs
    vecs.push_back(mk(1, 5, 192, 0, 0, 4'hF, 1, 0, 4'b0000, 4'b0000, 0, 0));
    vecs.push_back(mk(1, 0,  64, 0, 0, 4'hF, 1, 0, 4'b0000, 4'b0000, 0, 1));
    vecs.push_back(mk(0, 0,   0, 1, 0, 4'hF, 1, 1, 4'b0000, 4'b0000, 1, 1));
    vecs.push_back(mk(0, 0,   0, 1, 0, 4'hF, 1, 1, 4'b0000, 4'b0000, 0, 1));
    vecs.push_back(mk(0, 0,   0, 1, 0, 4'hF, 1, 1, 4'b0000, 4'b0000, 0, 1));
    vecs.push_back(mk(0, 0,   0, 1, 0, 4'hF, 1, 1, 4'b0001, 4'b0001, 0, 1));
    vecs.push_back(mk(0, 0,   0, 0, 0, 4'hF, 1, 0, 4'b0000, 4'b0000, 0, 0));

    // Reset state and release
    repeat (2) @(negedge aclk);
    #1;
    checkOutput("rst mux_ready", 64'(mux_ready), 64'd0);
    checkOutput("rst s_tready", 64'(s_axis_tready), 64'd0);
    checkOutput("rst m_tvalid", 64'(m_axis_tvalid), 64'd0);
    checkOutput("rst err", 64'(err), 64'd0);
    checkOutput("rst busy", 64'(busy), 64'd0);
    @(negedge aclk);
    aresetn = 1'b1;
    #1;
    checkOutput("release mux_ready before clock", 64'(mux_ready), 64'd0);
    @(negedge aclk);
    #1;
    checkOutput("release mux_ready after clock", 64'(mux_ready), 64'd1);

    $display("[TB] table vectors");
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(i);
    end
    s_axis_tvalid = 1'b0;
    mux_valid     = 1'b0;

    $display("[TB] backpressure and mid-transfer reset");
    runTransfer(0);
    runTransfer(4);

    $display("[TB] command FIFO full");
    @(negedge aclk);
    mux_valid     = 1'b1;
    mux_data      = {LEN_BITS'(64), DEST_BITS'(0)};
    s_axis_tvalid = 1'b0;
    m_axis_tready = 4'hF;
    @(negedge aclk);
    mux_valid = 1'b0;
    @(negedge aclk);
    #1;
    checkOutput("t6 holding tlast", 64'(m_axis_tlast), 64'h1);
    exp_dest = '{1, 2, 3, 0, 1};
    for (int k = 0; k < 4; k++) begin
      @(negedge aclk);
      mux_valid = 1'b1;
      mux_data  = {LEN_BITS'(64), DEST_BITS'(exp_dest[k])};
      #1;
      checkOutput($sformatf("t6 ready before push%0d", k + 1), 64'(mux_ready), 64'd1);
    end
    @(negedge aclk);
    mux_data = {LEN_BITS'(64), DEST_BITS'(exp_dest[4])};
    #1;
    checkOutput("t6 full after 4", 64'(mux_ready), 64'd0);
    @(negedge aclk);
    s_axis_tvalid = 1'b1;
    #1;
    checkOutput("t6 still full", 64'(mux_ready), 64'd0);
    @(negedge aclk);
    s_axis_tvalid = 1'b0;
    #1;
    checkOutput("t6 ready after pop", 64'(mux_ready), 64'd1);
    @(negedge aclk);
    mux_valid     = 1'b0;
    s_axis_tvalid = 1'b1;
    got  = 0;
    done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      if (c > 0) @(negedge aclk);
      #1;
      if (!busy) begin
        done = 1'b1;
      end else if (s_axis_tready && m_axis_tvalid != '0) begin
        if (got < 5) begin
          checkOutput($sformatf("t6 beat%0d tvalid", got), 64'(m_axis_tvalid),
                      64'(1) << exp_dest[got]);
        end
        got++;
      end
    end
    checkOutput("t6 drained beats", 64'(got), 64'd5);
    checkOutput("t6 idle reached", 64'(done), 64'd1);
    s_axis_tvalid = 1'b0;

    @(negedge aclk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
